// File: rtl/light_ctrl_pkg.sv
// Shared definitions for the light controller: LED output mode encodings and a
// helper that sizes counters.
package light_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_INVERT = 2'b11
  } mode_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/light_debounce.sv
// One switch channel: 2-flop synchronizer, debounce counter, debounced level
// (stb), toggle latch (tgl) and a one-cycle pulse marking each accepted change.
module light_debounce
  import light_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic swt_i,
  output logic stb_o,
  output logic tgl_o,
  output logic upd_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stb_q, stb_d;
  logic          tgl_q, tgl_d;
  logic          upd_q, upd_d;

  // The counter only runs while the synchronized input disagrees with stb;
  // on the DEB_CYCLES-th disagreeing cycle the new level is accepted.
  always_comb begin
    cnt_d = cnt_q;
    stb_d = stb_q;
    tgl_d = tgl_q;
    upd_d = 1'b0;
    if (sync2_q == stb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      cnt_d = '0;
      stb_d = sync2_q;
      upd_d = 1'b1;
      if (sync2_q) begin
        tgl_d = ~tgl_q;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      tgl_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      sync1_q <= swt_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      tgl_q   <= tgl_d;
      upd_q   <= upd_d;
    end
  end

  assign stb_o = stb_q;
  assign tgl_o = tgl_q;
  assign upd_o = upd_q;

endmodule

// File: rtl/light_ctrl.sv
// Multi-channel switch-to-LED controller: per-channel debouncers, one shared
// blink timebase, and a registered output mux selected by mode.
module light_ctrl
  import light_ctrl_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int DEB_CYCLES = 16,
  parameter int BLINK_DIV  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] swt,
  input  logic [1:0]     mode,
  output logic [NCH-1:0] led,
  output logic [NCH-1:0] chg
);

  localparam int BW = cnt_width(BLINK_DIV);

  logic [NCH-1:0] stb, tgl, upd;
  logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
  logic           phase_q, phase_d;
  logic [NCH-1:0] led_q, led_d;
  logic [NCH-1:0] chg_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    light_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .swt_i(swt[gi]),
      .stb_o(stb[gi]),
      .tgl_o(tgl[gi]),
      .upd_o(upd[gi])
    );
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Mode only steers this mux; it never touches debounce or blink state.
  always_comb begin
    led_d = stb;
    case (mode)
      MODE_DIRECT: led_d = stb;
      MODE_TOGGLE: led_d = tgl;
      MODE_BLINK:  led_d = stb & {NCH{phase_q}};
      MODE_INVERT: led_d = ~stb;
      default:     led_d = stb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_q       <= '0;
      chg_q       <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      chg_q       <= upd;
    end
  end

  assign led = led_q;
  assign chg = chg_q;

endmodule

// File: tb/tb_light_ctrl.sv
// Directed bench for light_ctrl with NCH=4, DEB_CYCLES=4, BLINK_DIV=3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_light_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] swt;
  logic [1:0] mode;
  logic [3:0] led;
  logic [3:0] chg;

  int vectors    = 0;
  int miscompares = 0;

  light_ctrl #(
    .NCH       (4),
    .DEB_CYCLES(4),
    .BLINK_DIV (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .swt (swt),
    .mode(mode),
    .led (led),
    .chg (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Two reset edges, then release with the given switch and mode levels.
  task automatic apply_reset(input logic [3:0] s, input logic [1:0] m);
    @(negedge clk);
    rst  = 1'b1;
    swt  = s;
    mode = m;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] exp_led;
    @(negedge clk);
    rst  = 1'b1;
    swt  = 4'b1111;
    mode = 2'b00;
    tick(2);
    vectors++;
    if (led !== 4'b0000 || chg !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_state: led=%b chg=%b, expected led=0000 chg=0000", led, chg);
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_led = (k == 7) ? 4'b1111 : 4'b0000;
      vectors++;
      if (led !== exp_led || chg !== exp_led) begin
        miscompares++;
        $display("FAIL reset_release_latency k=%0d: led=%b chg=%b, expected %b/%b",
                 k, led, chg, exp_led, exp_led);
      end
    end
  endtask

  task automatic test_direct;
    logic [3:0] exp_led, exp_chg;
    apply_reset(4'b0000, 2'b00);
    tick(3);
    swt = 4'b1010;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      exp_led = (k >= 7) ? 4'b1010 : 4'b0000;
      exp_chg = (k == 7) ? 4'b1010 : 4'b0000;
      vectors++;
      if (led !== exp_led || chg !== exp_chg) begin
        miscompares++;
        $display("FAIL direct k=%0d: led=%b chg=%b, expected led=%b chg=%b",
                 k, led, chg, exp_led, exp_chg);
      end
    end
  endtask

  task automatic test_bounce;
    apply_reset(4'b0000, 2'b00);
    tick(3);
    swt = 4'b0001;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      vectors++;
      if (led !== 4'b0000 || chg !== 4'b0000) begin
        miscompares++;
        $display("FAIL bounce k=%0d: led=%b chg=%b, expected 0000/0000", k, led, chg);
      end
      if (k == 3) swt = 4'b0000;
    end
  endtask

  task automatic test_toggle;
    logic [3:0] exp_led, exp_chg;
    apply_reset(4'b0010, 2'b01);
    for (int phase = 0; phase < 4; phase++) begin
      if (phase > 0) swt = (phase == 2) ? 4'b0010 : 4'b0000;
      for (int k = 1; k <= 10; k++) begin
        tick(1);
        case (phase)
          0:       exp_led = (k >= 7) ? 4'b0010 : 4'b0000;
          1:       exp_led = 4'b0010;
          2:       exp_led = (k >= 7) ? 4'b0000 : 4'b0010;
          default: exp_led = 4'b0000;
        endcase
        exp_chg = (k == 7) ? 4'b0010 : 4'b0000;
        vectors++;
        if (led !== exp_led || chg !== exp_chg) begin
          miscompares++;
          $display("FAIL toggle phase=%0d k=%0d: led=%b chg=%b, expected led=%b chg=%b",
                   phase, k, led, chg, exp_led, exp_chg);
        end
      end
    end
  endtask

  // Blink phase after release edge k is 1 for k=3..5, 9..11, ...; the LED
  // register shows the phase from the previous edge.
  task automatic test_blink;
    logic [3:0] exp_led;
    apply_reset(4'b1111, 2'b10);
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      if (k < 7) exp_led = 4'b0000;
      else       exp_led = ((((k - 1) / 3) % 2) == 1) ? 4'b1111 : 4'b0000;
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("FAIL blink k=%0d: led=%b, expected %b", k, led, exp_led);
      end
    end
    swt = 4'b0000;
    tick(7);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      vectors++;
      if (led !== 4'b0000) begin
        miscompares++;
        $display("FAIL blink_off k=%0d: led=%b, expected 0000", k, led);
      end
    end
  endtask

  task automatic test_invert_mode_switch;
    apply_reset(4'b0101, 2'b00);
    tick(9);
    vectors++;
    if (led !== 4'b0101) begin
      miscompares++;
      $display("FAIL invert_settle: led=%b, expected 0101", led);
    end
    mode = 2'b11;
    tick(1);
    vectors++;
    if (led !== 4'b1010 || chg !== 4'b0000) begin
      miscompares++;
      $display("FAIL invert_on: led=%b chg=%b, expected 1010/0000", led, chg);
    end
    mode = 2'b00;
    tick(1);
    vectors++;
    if (led !== 4'b0101 || chg !== 4'b0000) begin
      miscompares++;
      $display("FAIL invert_off: led=%b chg=%b, expected 0101/0000", led, chg);
    end
  endtask

  task automatic test_reset_mid_debounce;
    logic [3:0] exp_led;
    apply_reset(4'b0000, 2'b00);
    tick(3);
    swt = 4'b1111;
    tick(3);
    rst = 1'b1;
    tick(1);
    vectors++;
    if (led !== 4'b0000 || chg !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset_clear: led=%b chg=%b, expected 0000/0000", led, chg);
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_led = (k == 7) ? 4'b1111 : 4'b0000;
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("FAIL mid_reset_restart k=%0d: led=%b, expected %b", k, led, exp_led);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    swt  = 4'b0000;
    mode = 2'b00;
    test_reset();
    test_direct();
    test_bounce();
    test_toggle();
    test_blink();
    test_invert_mode_switch();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
